// File: rtl/otter_ir_pipeline.sv
// IR/PC register chain from fetch through writeback with
// load-use stall insertion, fetch-slot squash and per-stage valids.
module otter_ir_pipeline #(
    parameter int          XLEN = 32,
    parameter logic [31:0] NOP  = 32'h0000_0013
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [31:0]     IF_IR,
    input  logic [XLEN-1:0] IF_PC,
    input  logic            IF_VALID,
    input  logic            CLEAR,
    output logic            PC_WRITE,
    output logic            STALL,
    output logic [31:0]     DEC_IR,
    output logic [XLEN-1:0] DEC_PC,
    output logic            DEC_VALID,
    output logic [31:0]     EXE_IR,
    output logic [XLEN-1:0] EXE_PC,
    output logic            EXE_VALID,
    output logic [31:0]     MEM_IR,
    output logic [XLEN-1:0] MEM_PC,
    output logic            MEM_VALID,
    output logic [31:0]     WB_IR,
    output logic [XLEN-1:0] WB_PC,
    output logic            WB_VALID
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0]     ir;
        logic [XLEN-1:0] pc;
        logic            vld;
    } stage_t;

    stage_t dec_q, dec_d;
    stage_t exe_q, exe_d;
    stage_t mem_q, mem_d;
    stage_t wb_q,  wb_d;

    logic [4:0] exe_rd;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       hazard;

    function automatic logic uses_rs1(input logic [31:0] ir);
        logic u;
        unique case (ir[6:0])
            OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP: u = 1'b1;
            // CSRRW/CSRRS/CSRRC read rs1; the immediate forms do not
            OP_SYSTEM: u = (ir[14:12] != 3'd0) && (ir[14:12] <= 3'd3);
            default:   u = 1'b0;
        endcase
        return u;
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ir);
        logic u;
        unique case (ir[6:0])
            OP_BRANCH, OP_STORE, OP_OP: u = 1'b1;
            default:                    u = 1'b0;
        endcase
        return u;
    endfunction

    always_comb begin
        exe_rd  = exe_q.ir[11:7];
        rs1_hit = uses_rs1(dec_q.ir) && (dec_q.ir[19:15] == exe_rd);
        rs2_hit = uses_rs2(dec_q.ir) && (dec_q.ir[24:20] == exe_rd);
        hazard  = exe_q.vld && (exe_q.ir[6:0] == OP_LOAD)
                  && (exe_rd != 5'd0) && dec_q.vld
                  && (rs1_hit || rs2_hit);
    end

    always_comb begin
        dec_d = dec_q;
        exe_d = dec_q;
        mem_d = exe_q;
        wb_d  = mem_q;
        if (hazard) begin
            // hold decode, inject a bubble; CLEAR is ignored here
            exe_d = '{ir: NOP, pc: dec_q.pc, vld: 1'b0};
        end else if (IF_VALID && !CLEAR) begin
            dec_d = '{ir: IF_IR, pc: IF_PC, vld: 1'b1};
        end else begin
            dec_d = '{ir: NOP, pc: IF_PC, vld: 1'b0};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dec_q <= '{ir: NOP, pc: '0, vld: 1'b0};
            exe_q <= '{ir: NOP, pc: '0, vld: 1'b0};
            mem_q <= '{ir: NOP, pc: '0, vld: 1'b0};
            wb_q  <= '{ir: NOP, pc: '0, vld: 1'b0};
        end else begin
            dec_q <= dec_d;
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign STALL     = hazard;
    assign PC_WRITE  = !hazard;
    assign DEC_IR    = dec_q.ir;
    assign DEC_PC    = dec_q.pc;
    assign DEC_VALID = dec_q.vld;
    assign EXE_IR    = exe_q.ir;
    assign EXE_PC    = exe_q.pc;
    assign EXE_VALID = exe_q.vld;
    assign MEM_IR    = mem_q.ir;
    assign MEM_PC    = mem_q.pc;
    assign MEM_VALID = mem_q.vld;
    assign WB_IR     = wb_q.ir;
    assign WB_PC     = wb_q.pc;
    assign WB_VALID  = wb_q.vld;

endmodule
